// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: assembles 16-bit instructions from a byte-wide,
// 1-cycle-latency program memory and buffers them with their PC for the core.
module instr_prefetch_queue #(
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     mem_rd,
    output logic [ADDR_W-1:0]        mem_addr,
    input  logic [7:0]               mem_rdata,
    output logic [15:0]              instr_out,
    output logic [ADDR_W-1:0]        instr_pc,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    input  logic                     redirect,
    input  logic [ADDR_W-1:0]        redirect_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {HI, LO} state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   fetch_ptr;
    logic [ADDR_W-1:0]   lo_pc;
    logic                reserved;
    logic                rd_pending;
    logic                rd_lo;
    logic [7:0]          hi_reg;
    logic [15:0]         instr_mem [DEPTH];
    logic [ADDR_W-1:0]   pc_mem    [DEPTH];
    logic [PW-1:0]       rd_ptr, wr_ptr;
    logic                space_ok, issue_hi, issue_lo, push, pop;

    // A slot is reserved for the instruction in flight so a push can never hit a full FIFO.
    assign space_ok    = (count + CW'(reserved)) < CW'(DEPTH);
    assign instr_valid = (count != '0);
    assign push        = rd_pending && rd_lo && !redirect;
    assign pop         = instr_valid && instr_ready && !redirect;
    assign instr_out   = instr_valid ? instr_mem[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? pc_mem[rd_ptr]    : '0;

    always_ff @(posedge clk) begin
        if (rst) state <= HI;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        mem_rd     = 1'b0;
        mem_addr   = '0;
        issue_hi   = 1'b0;
        issue_lo   = 1'b0;
        if (redirect) begin
            state_next = HI;
        end else if (!rst) begin
            case (state)
                HI: begin
                    if (space_ok) begin
                        mem_rd     = 1'b1;
                        mem_addr   = fetch_ptr;
                        issue_hi   = 1'b1;
                        state_next = LO;
                    end
                end
                LO: begin
                    mem_rd     = 1'b1;
                    mem_addr   = fetch_ptr + ADDR_W'(1);
                    issue_lo   = 1'b1;
                    state_next = HI;
                end
                default: ;
            endcase
        end
    end

    // Clearing rd_pending on rst/redirect is what discards any byte still returning.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_ptr  <= RESET_PC;
            lo_pc      <= '0;
            reserved   <= 1'b0;
            rd_pending <= 1'b0;
            rd_lo      <= 1'b0;
            hi_reg     <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else if (redirect) begin
            fetch_ptr  <= redirect_pc & ~ADDR_W'(1);
            reserved   <= 1'b0;
            rd_pending <= 1'b0;
            rd_lo      <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            rd_pending <= mem_rd;
            rd_lo      <= issue_lo;
            if (issue_lo) begin
                fetch_ptr <= fetch_ptr + ADDR_W'(2);
                lo_pc     <= fetch_ptr;
            end
            if (rd_pending && !rd_lo)
                hi_reg <= mem_rdata;
            if (issue_hi)
                reserved <= 1'b1;
            else if (push)
                reserved <= 1'b0;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            instr_mem[wr_ptr] <= {hi_reg, mem_rdata};
            pc_mem[wr_ptr]    <= lo_pc;
        end
    end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed bench for instr_prefetch_queue against a memory returning mem[a]=a.
module tb_instr_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_rd;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic [15:0] instr_out;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic [2:0]  count;

    int applied = 0;
    int miscompares = 0;

    typedef struct {
        logic        rst;
        logic        ready;
        logic        redir;
        logic [7:0]  rpc;
        logic        exp_rd;
        logic [7:0]  exp_addr;
        logic        exp_valid;
        logic [15:0] exp_instr;
        logic [7:0]  exp_pc;
        logic [2:0]  exp_count;
    } vec_t;

    vec_t vecs[$];

    instr_prefetch_queue #(.ADDR_W(8), .DEPTH(4), .RESET_PC(8'h00)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .count       (count)
    );

    always #5 clk = ~clk;

    // Garbage on idle cycles makes any use of an unrequested byte visible.
    always @(posedge clk) mem_rdata <= mem_rd ? mem_addr : 8'hEE;

    function automatic vec_t mk(input logic r, input logic rdy, input logic rd, input logic [7:0] rpc,
                                input logic erd, input logic [7:0] eaddr, input logic ev,
                                input logic [15:0] ei, input logic [7:0] ep, input logic [2:0] ec);
        vec_t v;
        v.rst = r; v.ready = rdy; v.redir = rd; v.rpc = rpc;
        v.exp_rd = erd; v.exp_addr = eaddr; v.exp_valid = ev;
        v.exp_instr = ei; v.exp_pc = ep; v.exp_count = ec;
        return v;
    endfunction

    function automatic void add(input logic r, input logic rdy, input logic rd, input logic [7:0] rpc,
                                input logic erd, input logic [7:0] eaddr, input logic ev,
                                input logic [15:0] ei, input logic [7:0] ep, input logic [2:0] ec);
        vecs.push_back(mk(r, rdy, rd, rpc, erd, eaddr, ev, ei, ep, ec));
    endfunction

    // Two reset cycles then ready held low until the FIFO is full and fetch stalls.
    function automatic void addFill();
        add(1,0,0,0, 0,8'h00, 0,16'h0000,8'h00,0);
        add(1,0,0,0, 0,8'h00, 0,16'h0000,8'h00,0);
        add(0,0,0,0, 1,8'h00, 0,16'h0000,8'h00,0);
        add(0,0,0,0, 1,8'h01, 0,16'h0000,8'h00,0);
        add(0,0,0,0, 1,8'h02, 0,16'h0000,8'h00,0);
        add(0,0,0,0, 1,8'h03, 1,16'h0001,8'h00,1);
        add(0,0,0,0, 1,8'h04, 1,16'h0001,8'h00,1);
        add(0,0,0,0, 1,8'h05, 1,16'h0001,8'h00,2);
        add(0,0,0,0, 1,8'h06, 1,16'h0001,8'h00,2);
        add(0,0,0,0, 1,8'h07, 1,16'h0001,8'h00,3);
        add(0,0,0,0, 0,8'h00, 1,16'h0001,8'h00,3);
        add(0,0,0,0, 0,8'h00, 1,16'h0001,8'h00,4);
        add(0,0,0,0, 0,8'h00, 1,16'h0001,8'h00,4);
        add(0,0,0,0, 0,8'h00, 1,16'h0001,8'h00,4);
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        rst         = v.rst;
        instr_ready = v.ready;
        redirect    = v.redir;
        redirect_pc = v.rpc;
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        @(negedge clk);
        applied++;
        if (mem_rd !== v.exp_rd || (v.exp_rd && mem_addr !== v.exp_addr) ||
            instr_valid !== v.exp_valid || instr_out !== v.exp_instr ||
            instr_pc !== v.exp_pc || count !== v.exp_count) begin
            miscompares++;
            $display("[TB] FAIL %s (vector %0d): got rd=%b addr=%h valid=%b instr=%h pc=%h count=%0d, want rd=%b addr=%h valid=%b instr=%h pc=%h count=%0d",
                     tag, applied, mem_rd, mem_addr, instr_valid, instr_out, instr_pc, count,
                     v.exp_rd, v.exp_addr, v.exp_valid, v.exp_instr, v.exp_pc, v.exp_count);
        end
    endtask

    task automatic hs(input string tag, input logic r, input logic rdy, input logic rd, input logic [7:0] rpc,
                      input logic erd, input logic [7:0] eaddr, input logic ev,
                      input logic [15:0] ei, input logic [7:0] ep, input logic [2:0] ec);
        vec_t v;
        v = mk(r, rdy, rd, rpc, erd, eaddr, ev, ei, ep, ec);
        applyStimulus(v);
        checkOutput(tag, v);
    endtask

    initial begin
        // Startup with ready held: first instruction three cycles after first issue.
        add(1,1,0,0, 0,8'h00, 0,16'h0000,8'h00,0);
        add(1,1,0,0, 0,8'h00, 0,16'h0000,8'h00,0);
        add(0,1,0,0, 1,8'h00, 0,16'h0000,8'h00,0);
        add(0,1,0,0, 1,8'h01, 0,16'h0000,8'h00,0);
        add(0,1,0,0, 1,8'h02, 0,16'h0000,8'h00,0);
        add(0,1,0,0, 1,8'h03, 1,16'h0001,8'h00,1);
        add(0,1,0,0, 1,8'h04, 0,16'h0000,8'h00,0);
        add(0,1,0,0, 1,8'h05, 1,16'h0203,8'h02,1);
        add(0,1,0,0, 1,8'h06, 0,16'h0000,8'h00,0);
        add(0,1,0,0, 1,8'h07, 1,16'h0405,8'h04,1);
        addFill();
        // Drain in order, refetch resumes at 0x08 as soon as a slot frees.
        add(0,1,0,0, 0,8'h00, 1,16'h0001,8'h00,4);
        add(0,1,0,0, 1,8'h08, 1,16'h0203,8'h02,3);
        add(0,1,0,0, 1,8'h09, 1,16'h0405,8'h04,2);
        add(0,1,0,0, 1,8'h0A, 1,16'h0607,8'h06,1);
        add(0,1,0,0, 1,8'h0B, 1,16'h0809,8'h08,1);
        addFill();

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput("table", vecs[i]);
        end

        // Redirect on a full FIFO with ready high: no pop, odd PC aligned down.
        hs("redir_full",  0,1,1,8'h41, 0,8'h00, 1,16'h0001,8'h00,4);
        hs("redir_next",  0,1,0,8'h00, 1,8'h40, 0,16'h0000,8'h00,0);
        hs("redir_lo",    0,1,0,8'h00, 1,8'h41, 0,16'h0000,8'h00,0);
        hs("redir_hi2",   0,1,0,8'h00, 1,8'h42, 0,16'h0000,8'h00,0);
        hs("redir_first", 0,1,0,8'h00, 1,8'h43, 1,16'h4041,8'h40,1);

        // Redirect while the low byte 0x43 returns, then wrap from 0xFE to 0x00.
        hs("wrap_redir",  0,1,1,8'hFE, 0,8'h00, 0,16'h0000,8'h00,0);
        hs("wrap_hi",     0,1,0,8'h00, 1,8'hFE, 0,16'h0000,8'h00,0);
        hs("wrap_lo",     0,1,0,8'h00, 1,8'hFF, 0,16'h0000,8'h00,0);
        hs("wrap_zero",   0,1,0,8'h00, 1,8'h00, 0,16'h0000,8'h00,0);
        hs("wrap_feff",   0,1,0,8'h00, 1,8'h01, 1,16'hFEFF,8'hFE,1);
        hs("wrap_gap",    0,1,0,8'h00, 1,8'h02, 0,16'h0000,8'h00,0);
        hs("wrap_0001",   0,1,0,8'h00, 1,8'h03, 1,16'h0001,8'h00,1);

        // Back-to-back redirects: the second one wins.
        hs("b2b_first",   0,1,1,8'h80, 0,8'h00, 0,16'h0000,8'h00,0);
        hs("b2b_second",  0,1,1,8'h21, 0,8'h00, 0,16'h0000,8'h00,0);
        hs("b2b_hi",      0,1,0,8'h00, 1,8'h20, 0,16'h0000,8'h00,0);
        hs("b2b_lo",      0,1,0,8'h00, 1,8'h21, 0,16'h0000,8'h00,0);
        hs("b2b_next",    0,1,0,8'h00, 1,8'h22, 0,16'h0000,8'h00,0);
        hs("b2b_out",     0,1,0,8'h00, 1,8'h23, 1,16'h2021,8'h20,1);

        // Redirect ignored under rst, honoured in the first cycle after it.
        hs("rst_a",       1,0,0,8'h00, 0,8'h00, 0,16'h0000,8'h00,0);
        hs("rst_redir",   1,0,1,8'h30, 0,8'h00, 0,16'h0000,8'h00,0);
        hs("post_redir",  0,0,1,8'h11, 0,8'h00, 0,16'h0000,8'h00,0);
        hs("post_hi",     0,0,0,8'h00, 1,8'h10, 0,16'h0000,8'h00,0);
        hs("post_lo",     0,0,0,8'h00, 1,8'h11, 0,16'h0000,8'h00,0);
        hs("post_hi2",    0,0,0,8'h00, 1,8'h12, 0,16'h0000,8'h00,0);
        hs("post_out",    0,0,0,8'h00, 1,8'h13, 1,16'h1011,8'h10,1);
        hs("post_hi3",    0,0,0,8'h00, 1,8'h14, 1,16'h1011,8'h10,1);
        hs("post_cnt2",   0,0,0,8'h00, 1,8'h15, 1,16'h1011,8'h10,2);

        // Mid-run rst pulse with count=2 and a byte in flight.
        hs("pulse_rst",   1,0,0,8'h00, 0,8'h00, 1,16'h1011,8'h10,2);
        hs("pulse_after", 0,0,0,8'h00, 1,8'h00, 0,16'h0000,8'h00,0);
        hs("pulse_lo",    0,0,0,8'h00, 1,8'h01, 0,16'h0000,8'h00,0);
        hs("pulse_hi2",   0,0,0,8'h00, 1,8'h02, 0,16'h0000,8'h00,0);
        hs("pulse_out",   0,0,0,8'h00, 1,8'h03, 1,16'h0001,8'h00,1);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_queue.md
Name: instr_prefetch_queue

Overview:
- Fetch stage upstream of the CPU core's decode/execute path.
- Reads 16-bit instructions from a byte-wide program memory with 1-cycle read latency, two byte reads per instruction, high byte at the even address.
- Buffers assembled instructions, with their PC, in a small FIFO and hands them to the core over a valid/ready handshake.
- On a taken branch or jump, the core asserts redirect; the queue flushes and refetches from the new PC.

Parameters:
- ADDR_W, 8, program byte-address width. PC arithmetic is modulo 2^ADDR_W.
- DEPTH, 4, FIFO entries (power of two, at least 2).
- RESET_PC, 0, fetch start address after reset (even).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_rd  output  1  program memory read strobe.
- mem_addr  output  ADDR_W  program memory byte address.
- mem_rdata  input  8  read data, valid the cycle after mem_rd=1.
- instr_out  output  16  head instruction, {byte@pc, byte@pc+1}.
- instr_pc  output  ADDR_W  byte address of the head instruction.
- instr_valid  output  1  FIFO not empty.
- instr_ready  input  1  core accepts the head this cycle.
- redirect  input  1  flush and restart fetch.
- redirect_pc  input  ADDR_W  new fetch address; bit 0 is ignored (forced to 0).
- count  output  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset state: count=0, instr_valid=0, instr_out=0, instr_pc=0, fetch_ptr=RESET_PC, FSM=HI, no read in flight.
- While rst=1: mem_rd=0, and redirect is ignored.
- FSM states:
  - HI: may issue the even byte.
  - LO: issues the odd byte unconditionally.
- mem_rd and mem_addr are combinational from registered state. Both are forced to 0 while rst=1 or redirect=1.
- HI issue condition: count + reserved < DEPTH, using registered count only (a same-cycle pop is not credited).
  - On issue: mem_addr=fetch_ptr, set reserved=1, go to LO.
- LO: mem_addr=fetch_ptr+1; fetch_ptr advances by 2 (wraps); go to HI.
- Response path:
  - A returning high byte is latched into hi_reg.
  - A returning low byte pushes {hi_reg, mem_rdata} with pc=fetch_ptr_of_hi, and clears reserved.
- Latency and throughput:
  - First instr_valid appears 3 cycles after the first HI issue.
  - Sustained rate is 1 instruction per 2 cycles.
- Pop occurs when instr_valid && instr_ready && !redirect. The head advances next cycle.
- Push and pop in the same cycle leave count unchanged.
- A push never occurs when full (guaranteed by the reservation rule).
- instr_out and instr_pc are 0 when the FIFO is empty.
- Redirect (priority over everything except rst), effective at the next edge:
  - FIFO empty, count=0, reserved=0, FSM=HI, fetch_ptr={redirect_pc[ADDR_W-1:1],0}.
  - Any byte returning in the redirect cycle is discarded.
  - Any handshake in the redirect cycle is ignored.
- Back-to-back redirects: the last one wins.
- Redirect in the cycle after reset deassertion is honoured.
- Wrap-around: fetch_ptr wraps from (2^ADDR_W-2) to 0. An instruction at pc 2^ADDR_W-2 reads bytes 2^ADDR_W-2 and 2^ADDR_W-1.
- rst mid-operation: same effect as a redirect to RESET_PC. In-flight data is dropped, and nothing is pushed in the cycle after rst falls.

Test Plan:
- Memory model mem[a]=a.
- Release rst with instr_ready=1 held:
  - Cycle0: mem_rd=1, addr 0x00.
  - Cycle1: addr 0x01.
  - Cycle3: instr_valid=1, instr_out=0x0001, instr_pc=0x00.
  - Cycle5: 0x0203, pc 0x02.
  - Count never exceeds 1.
- instr_ready=0 held: FIFO fills with 0x0001, 0x0203, 0x0405, 0x0607; count=4; mem_rd stays 0 thereafter. Raise ready: drains in that order one per cycle, then refetch resumes at 0x08.
- Full FIFO, assert redirect with redirect_pc=0x41 (ready=1 same cycle):
  - No pop counted in that cycle.
  - Next cycle: count=0, instr_valid=0, mem_addr=0x40.
  - Three cycles later: instr_out=0x4041, instr_pc=0x40.
- Redirect to 0xFE: outputs 0xFEFF at pc 0xFE, then 0x0001 at pc 0x00.
- Redirect asserted in the cycle a low byte returns: that byte is not pushed; the next output is from the new PC only.
- With count=2 and a read in flight, pulse rst for 1 cycle:
  - Next cycle count=0, instr_valid=0.
  - The cycle after rst falls: mem_addr=RESET_PC.
  - First output 0x0001.
